// File: rtl/pipeline_types.sv
// Inter-stage payloads for the five-stage pipeline and the memory-stage FSM
// state encoding.
package pipeline_types;

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_en;
    logic [6:0] opcode;
    logic [2:0] func3;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_t;

  typedef struct packed {
    logic [31:0] data;
  } src_t;

  typedef struct packed {
    ctrl_t ctrl;
    reg_t  rd;
    src_t  rs2;
  } ex_mem_t;

  typedef struct packed {
    ctrl_t ctrl;
    reg_t  rd;
  } mem_wb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/rv32_isa.sv
// RV32I encodings used by the memory stage: load/store opcodes, func3 width
// codes and the natural-alignment rule for a given access size.
package rv32_isa;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // size is func3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b01:   is_aligned = ~offset[0];
      2'b10:   is_aligned = (offset == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data bus and RV32I sub-word accesses:
// load extraction/extension and store byte-enable/data replication.
module mem_lane_align
  import rv32_isa::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (func3)
      F3Lb:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3Lbu:   load_data = {24'h0, shifted[7:0]};
      F3Lh:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3Lhu:   load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

  // Sub-word store data is replicated so every enabled lane sees the value.
  always_comb begin
    case (func3[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: pass-through for ALU ops, request/grant data
// port for loads and stores, with misalignment drop and bus timeout.
module mem_stage
  import rv32_isa::*;
  import pipeline_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_t     ex_mem_i,
  output logic        ex_mem_ready_o,
  output mem_wb_t     mem_wb_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q;
  ctrl_t         lat_ctrl;
  reg_t          lat_rd;
  logic [31:0]   lat_store;
  logic          lat_we;
  mem_wb_t       wb_q, wb_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;
  logic          resp, timeout, done, busy;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata, load_data;

  mem_lane_align u_lane (
    .func3      (lat_ctrl.func3),
    .offset     (lat_rd.data[1:0]),
    .store_data (lat_store),
    .rdata      (dmem_rdata_i),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  assign busy    = (state_q != IDLE);
  // A response in REQ only counts once the request is granted in that cycle.
  assign resp    = ((state_q == REQ) & dmem_gnt_i & dmem_rvalid_i)
                 | ((state_q == WAIT) & dmem_rvalid_i);
  assign timeout = busy & ~resp & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign done    = resp | timeout;

  always_comb begin
    state_d         = state_q;
    wb_d            = wb_q;
    wb_d.ctrl.valid = 1'b0;
    misalign_d      = 1'b0;
    bus_err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mem_i.ctrl.valid) begin
          if (!ex_mem_i.ctrl.mem_en) begin
            wb_d.ctrl = ex_mem_i.ctrl;
            wb_d.rd   = ex_mem_i.rd;
          end else if (!is_aligned(ex_mem_i.ctrl.func3[1:0], ex_mem_i.rd.data[1:0])) begin
            wb_d.ctrl       = ex_mem_i.ctrl;
            wb_d.ctrl.wb_en = 1'b0;
            wb_d.rd         = ex_mem_i.rd;
            misalign_d      = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (done)            state_d = IDLE;
        else if (dmem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      bus_err_d       = timeout | dmem_err_i;
      wb_d.ctrl       = lat_ctrl;
      wb_d.ctrl.valid = 1'b1;
      wb_d.ctrl.wb_en = lat_ctrl.wb_en & ~lat_we & ~bus_err_d;
      wb_d.rd.addr    = lat_rd.addr;
      wb_d.rd.data    = lat_we ? lat_rd.data : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_ctrl   <= '0;
      lat_rd     <= '0;
      lat_store  <= '0;
      lat_we     <= 1'b0;
      wb_q       <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= busy ? cnt_q + CntW'(1) : '0;
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      if (state_q == IDLE && state_d == REQ) begin
        lat_ctrl  <= ex_mem_i.ctrl;
        lat_rd    <= ex_mem_i.rd;
        lat_store <= ex_mem_i.rs2.data;
        lat_we    <= (ex_mem_i.ctrl.opcode == OpStore);
      end
    end
  end

  assign ex_mem_ready_o = (state_q == IDLE);
  assign mem_wb_o       = wb_q;
  assign misalign_o     = misalign_q;
  assign bus_err_o      = bus_err_q;
  assign dmem_req_o     = (state_q == REQ);
  assign dmem_we_o      = lat_we;
  assign dmem_addr_o    = {lat_rd.data[31:2], 2'b00};
  assign dmem_be_o      = busy ? lane_be : 4'b0000;
  assign dmem_wdata_o   = busy ? lane_wdata : 32'h0;
  assign dbg_state      = state_q;

endmodule
